// File: rtl/alu_seq_pkg.sv
// Shared op codes and FSM state encodings for the sequential ALU.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OpAnd   = 4'b0000,
    OpOr    = 4'b0001,
    OpAdd   = 4'b0010,
    OpXor   = 4'b0011,
    OpSub   = 4'b0110,
    OpSlt   = 4'b0111,
    OpSltu  = 4'b1000,
    OpSll   = 4'b1001,
    OpSrl   = 4'b1010,
    OpSra   = 4'b1011,
    OpMul   = 4'b1100,
    OpMulhu = 4'b1101,
    OpDivu  = 4'b1110,
    OpRemu  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } alu_state_e;

  // MUL/MULHU/DIVU/REMU share the 2'b11 prefix; ctl[1] picks divide, ctl[0] the high half.
  function automatic logic is_iter_op(logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Bit-serial shift-add multiplier / restoring divider sharing one 2*Width accumulator.
module alu_iter_muldiv #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [Width-1:0] op_a_i,
  input  logic [Width-1:0] op_b_i,
  output logic             done_o,
  output logic [Width-1:0] lo_o,
  output logic [Width-1:0] hi_o
);

  localparam int unsigned CntW = $clog2(Width) + 1;

  logic [2*Width-1:0] acc_q, acc_d, step;
  logic [Width-1:0]   opb_q;
  logic               div_q;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [Width:0]     rem_t, diff, sum;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    rem_t = {acc_q[2*Width-1:Width], acc_q[Width-1]};
    diff  = rem_t - {1'b0, opb_q};
    sum   = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    if (div_q) begin
      if (rem_t >= {1'b0, opb_q}) step = {diff[Width-1:0], acc_q[Width-2:0], 1'b1};
      else                        step = {rem_t[Width-1:0], acc_q[Width-2:0], 1'b0};
    end else begin
      step = {sum, acc_q[Width-1:1]};
    end

    acc_d = acc_q;
    cnt_d = cnt_q;
    if (start_i) begin
      acc_d = {{Width{1'b0}}, op_a_i};
      cnt_d = CntW'(Width);
    end else if (cnt_q != '0) begin
      acc_d = step;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      if (start_i) begin
        opb_q <= op_b_i;
        div_q <= div_i;
      end
    end
  end

  // Outputs carry the value being committed on the final step.
  assign done_o = (cnt_q == CntW'(1));
  assign lo_o   = step[Width-1:0];
  assign hi_o   = step[2*Width-1:Width];

endmodule

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with valid/ready handshakes on operands and result.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WORDSIZE = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORDSIZE-1:0] in1,
  input  logic [WORDSIZE-1:0] in2,
  input  logic [3:0]          ctl,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] result,
  output logic                zero
);

  localparam int unsigned SHW = $clog2(WORDSIZE);

  alu_state_e          state_q;
  logic [WORDSIZE-1:0] result_q, alu_res, iter_lo, iter_hi, iter_res;
  logic                zero_q, out_valid_q, hi_sel_q, iter_done, accept;
  logic [SHW-1:0]      shamt;

  assign shamt  = in2[SHW-1:0];
  assign accept = in_valid && (state_q == StIdle);

  always_comb begin
    alu_res = '0;
    case (ctl)
      OpAnd:   alu_res = in1 & in2;
      OpOr:    alu_res = in1 | in2;
      OpAdd:   alu_res = in1 + in2;
      OpXor:   alu_res = in1 ^ in2;
      OpSub:   alu_res = in1 - in2;
      OpSlt:   alu_res = {{(WORDSIZE-1){1'b0}}, $signed(in1) < $signed(in2)};
      OpSltu:  alu_res = {{(WORDSIZE-1){1'b0}}, in1 < in2};
      OpSll:   alu_res = in1 << shamt;
      OpSrl:   alu_res = in1 >> shamt;
      OpSra:   alu_res = $signed(in1) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  alu_iter_muldiv #(
    .Width (WORDSIZE)
  ) u_iter (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (accept && is_iter_op(ctl)),
    .div_i   (ctl[1]),
    .op_a_i  (in1),
    .op_b_i  (in2),
    .done_o  (iter_done),
    .lo_o    (iter_lo),
    .hi_o    (iter_hi)
  );

  assign iter_res = hi_sel_q ? iter_hi : iter_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      hi_sel_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (is_iter_op(ctl)) begin
              state_q  <= ctl[1] ? StDiv : StMul;
              hi_sel_q <= ctl[0];
            end else begin
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StMul, StDiv: begin
          if (iter_done) begin
            result_q    <= iter_res;
            zero_q      <= (iter_res == '0);
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq at WORDSIZE 32 plus a WORDSIZE 16 instance.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in1 = '0, in2 = '0;
  logic [3:0]  ctl = '0;
  logic        in_ready, out_valid, zero;
  logic [31:0] result;

  logic        in_valid16 = 1'b0, out_ready16 = 1'b0;
  logic [15:0] in1_16 = '0, in2_16 = '0;
  logic [3:0]  ctl16 = '0;
  logic        in_ready16, out_valid16, zero16;
  logic [15:0] result16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WORDSIZE(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .ctl       (ctl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  alu_seq #(.WORDSIZE(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .in1       (in1_16),
    .in2       (in2_16),
    .ctl       (ctl16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .result    (result16),
    .zero      (zero16)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        ez;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1; ctl = c; in1 = a; in2 = b;
    @(negedge clk);
    in_valid = 1'b0; in1 = $urandom; in2 = $urandom; ctl = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r = result;
    z = zero;
  endtask

  task automatic run_op16(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic z, output int lat);
    in_valid16 = 1'b1; ctl16 = c; in1_16 = a; in2_16 = b;
    @(negedge clk);
    in_valid16 = 1'b0; in1_16 = 16'($urandom); in2_16 = 16'($urandom);
    lat = 1;
    while (!out_valid16 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r = result16;
    z = zero16;
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
  endtask

  vec_t        vecs[$];
  logic [31:0] r;
  logic [15:0] r16;
  logic        z;
  int          lat;

  initial begin
    vecs.push_back('{"add_wrap",  4'b0010, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1});
    vecs.push_back('{"sub_neg",   4'b0110, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1});
    vecs.push_back('{"slt",       4'b0111, 32'h8000_0000, 32'h1,         32'h1,         1'b0, 1});
    vecs.push_back('{"sltu",      4'b1000, 32'h8000_0000, 32'h1,         32'h0,         1'b1, 1});
    vecs.push_back('{"sra",       4'b1011, 32'h8000_0000, 32'h21,        32'hC000_0000, 1'b0, 1});
    vecs.push_back('{"and",       4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1});
    vecs.push_back('{"or",        4'b0001, 32'hF0,        32'h0F,        32'hFF,        1'b0, 1});
    vecs.push_back('{"xor",       4'b0011, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1});
    vecs.push_back('{"sll",       4'b1001, 32'h1,         32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1});
    vecs.push_back('{"srl",       4'b1010, 32'h8000_0000, 32'h4,         32'h0800_0000, 1'b0, 1});
    vecs.push_back('{"undef",     4'b0100, 32'h1234,      32'h5678,      32'h0,         1'b1, 1});
    vecs.push_back('{"mulhu_max", 4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33});
    vecs.push_back('{"mul",       4'b1100, 32'd7,         32'd6,         32'd42,        1'b0, 33});
    vecs.push_back('{"mul_wrap",  4'b1100, 32'h1_0000,    32'h1_0000,    32'h0,         1'b1, 33});
    vecs.push_back('{"divu",      4'b1110, 32'd100,       32'd7,         32'd14,        1'b0, 33});
    vecs.push_back('{"remu",      4'b1111, 32'd100,       32'd7,         32'd2,         1'b0, 33});
    vecs.push_back('{"divu_z",    4'b1110, 32'hDEAD,      32'h0,         32'hFFFF_FFFF, 1'b0, 33});
    vecs.push_back('{"remu_z",    4'b1111, 32'h1234,      32'h0,         32'h1234,      1'b0, 33});
    vecs.push_back('{"mulhu",     4'b1101, 32'h1_0000,    32'h1_0000,    32'h1,         1'b0, 33});

    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(in_ready), 32'h1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_result",    result, 32'h0);
    check("rst_zero",      32'(zero), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat);
      check({vecs[i].name, "_res"}, r, vecs[i].exp);
      check({vecs[i].name, "_zero"}, 32'(z), 32'(vecs[i].ez));
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({vecs[i].name, "_idle"}, 32'(in_ready), 32'h1);
      check({vecs[i].name, "_ovdrop"}, 32'(out_valid), 32'h0);
    end

    // Back-pressure in DONE: result must hold and a new request must be ignored.
    run_op(4'b0010, 32'd3, 32'd4, r, z, lat);
    check("bp_first", r, 32'd7);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        in_valid = 1'b1; ctl = 4'b0000; in1 = '0; in2 = '0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_hold_res", result, 32'd7);
      check("bp_hold_valid", 32'(out_valid), 32'h1);
      check("bp_in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_idle", 32'(in_ready), 32'h1);
    check("bp_release_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    check("bp_ignored_op", 32'(out_valid), 32'h0);

    // Reset partway through a DIVU must discard everything.
    in_valid = 1'b1; ctl = 4'b1110; in1 = 32'd1000; in2 = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_result", result, 32'h0);
    check("mid_rst_zero", 32'(zero), 32'h0);
    check("mid_rst_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'h1);
    repeat (40) @(negedge clk);
    check("post_rst_no_leak", 32'(out_valid), 32'h0);
    run_op(4'b1111, 32'd100, 32'd7, r, z, lat);
    check("post_rst_remu", r, 32'd2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Narrow instance: iterative ops take WORDSIZE+1 = 17 cycles.
    run_op16(4'b1101, 16'hFFFF, 16'hFFFF, r16, z, lat);
    check("w16_mulhu_res", 32'(r16), 32'h0000_FFFE);
    check("w16_mulhu_lat", 32'(lat), 32'd17);
    run_op16(4'b1110, 16'd100, 16'd7, r16, z, lat);
    check("w16_divu_res", 32'(r16), 32'd14);
    check("w16_divu_lat", 32'(lat), 32'd17);
    run_op16(4'b1111, 16'h1234, 16'h0, r16, z, lat);
    check("w16_remu_z", 32'(r16), 32'h1234);
    run_op16(4'b0010, 16'hFFFF, 16'h1, r16, z, lat);
    check("w16_add_res", 32'(r16), 32'h0);
    check("w16_add_zero", 32'(z), 32'h1);
    check("w16_add_lat", 32'(lat), 32'd1);
    run_op16(4'b1011, 16'h8000, 16'h0011, r16, z, lat);
    check("w16_sra", 32'(r16), 32'h0000_C000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
